dp_sched_ctrl: RTL

//  Schedule controller (FSM) for the shared-unit datapath: one MUL/DIV unit (mul1) and one AND/OR/XOR unit (log1).

---
 rtl/dp_sched_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dp_sched_ctrl.sv
// Schedule controller for the shared-unit datapath (one MUL/DIV unit, one
// AND/OR/XOR unit). A Moore FSM walks a fixed six-step schedule and decodes
// every operand select, op code, register enable, result_en and done_next
// purely from the registered state.
module dp_sched_ctrl #(
  parameter int SEL_W   = 4,
  parameter int STATE_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [SEL_W-1:0] mul1_sel1,
  output logic [SEL_W-1:0] mul1_sel2,
  output logic             mul1_op,
  output logic [SEL_W-1:0] log1_sel1,
  output logic [SEL_W-1:0] log1_sel2,
  output logic [1:0]       log1_op,
  output logic             reg_mul2_en,
  output logic             reg_mul4_en,
  output logic             reg_mul6_en,
  output logic             reg_log9_en,
  output logic             reg_log10_en,
  output logic             reg_log13_en,
  output logic             reg_log14_en,
  output logic             result_en,
  output logic             done_next
);

  // Operand-select codes shared by both functional units.
  localparam logic [SEL_W-1:0] SEL_I1    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_I2    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_I3    = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_I4    = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_I5    = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_I6    = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_I7    = SEL_W'(6);
  localparam logic [SEL_W-1:0] SEL_I8    = SEL_W'(7);
  localparam logic [SEL_W-1:0] SEL_MUL2  = SEL_W'(8);
  localparam logic [SEL_W-1:0] SEL_MUL4  = SEL_W'(9);
  localparam logic [SEL_W-1:0] SEL_MUL6  = SEL_W'(10);
  localparam logic [SEL_W-1:0] SEL_LOG9  = SEL_W'(11);
  localparam logic [SEL_W-1:0] SEL_LOG10 = SEL_W'(12);
  localparam logic [SEL_W-1:0] SEL_LOG13 = SEL_W'(13);
  localparam logic [SEL_W-1:0] SEL_ZERO  = SEL_W'(15);

  localparam logic       MUL_OP_MULT = 1'b0;
  localparam logic       MUL_OP_DIV  = 1'b1;
  localparam logic [1:0] LOG_OP_AND  = 2'b00;
  localparam logic [1:0] LOG_OP_OR   = 2'b01;
  localparam logic [1:0] LOG_OP_XOR  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    IDLE = STATE_W'(0),
    S1   = STATE_W'(1),
    S2   = STATE_W'(2),
    S3   = STATE_W'(3),
    S4   = STATE_W'(4),
    S5   = STATE_W'(5),
    S6   = STATE_W'(6)
  } state_e;

  state_e state_q, state_d;

  // State register; reset drops straight back to IDLE, discarding any partial run.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode from the registered state only.
  // NOTE: every output gets its idle value first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = IDLE;
    busy         = 1'b0;
    mul1_sel1    = SEL_ZERO;
    mul1_sel2    = SEL_ZERO;
    mul1_op      = MUL_OP_MULT;
    log1_sel1    = SEL_ZERO;
    log1_sel2    = SEL_ZERO;
    log1_op      = LOG_OP_AND;
    reg_mul2_en  = 1'b0;
    reg_mul4_en  = 1'b0;
    reg_mul6_en  = 1'b0;
    reg_log9_en  = 1'b0;
    reg_log10_en = 1'b0;
    reg_log13_en = 1'b0;
    reg_log14_en = 1'b0;
    result_en    = 1'b0;
    done_next    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = start ? S1 : IDLE;
      end
      S1: begin
        state_d     = S2;
        busy        = 1'b1;
        mul1_sel1   = SEL_I1;
        mul1_sel2   = SEL_I2;
        mul1_op     = MUL_OP_MULT;
        reg_mul2_en = 1'b1;
      end
      S2: begin
        state_d     = S3;
        busy        = 1'b1;
        mul1_sel1   = SEL_I3;
        mul1_sel2   = SEL_I4;
        mul1_op     = MUL_OP_DIV;
        reg_mul4_en = 1'b1;
        log1_sel1   = SEL_I5;
        log1_sel2   = SEL_I6;
        log1_op     = LOG_OP_AND;
        reg_log9_en = 1'b1;
      end
      S3: begin
        state_d      = S4;
        busy         = 1'b1;
        mul1_sel1    = SEL_MUL2;
        mul1_sel2    = SEL_MUL4;
        mul1_op      = MUL_OP_MULT;
        reg_mul6_en  = 1'b1;
        log1_sel1    = SEL_I7;
        log1_sel2    = SEL_I8;
        log1_op      = LOG_OP_OR;
        reg_log10_en = 1'b1;
      end
      S4: begin
        state_d      = S5;
        busy         = 1'b1;
        log1_sel1    = SEL_LOG9;
        log1_sel2    = SEL_LOG10;
        log1_op      = LOG_OP_XOR;
        reg_log13_en = 1'b1;
      end
      S5: begin
        state_d      = S6;
        busy         = 1'b1;
        log1_sel1    = SEL_MUL6;
        log1_sel2    = SEL_LOG13;
        log1_op      = LOG_OP_AND;
        reg_log14_en = 1'b1;
      end
      S6: begin
        state_d   = IDLE;
        busy      = 1'b1;
        result_en = 1'b1;
        done_next = 1'b1;
      end
      // Unused codes keep idle outputs and fall back to IDLE.
      default: state_d = IDLE;
    endcase
  end

endmodule
